// File: rtl/debounced_input_pio_pkg.sv
// Shared constants for the debounced input PIO: Avalon-MM address width and register offsets.
package debounced_input_pio_pkg;

  localparam int ADDR_W = 3;

  localparam logic [ADDR_W-1:0] ADDR_DATA         = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_RAW          = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_IRQ_MASK     = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_EDGE_CAPTURE = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_RISE_EN      = 3'd4;
  localparam logic [ADDR_W-1:0] ADDR_FALL_EN      = 3'd5;

endpackage

// File: rtl/pio_debounce_bit.sv
// One input bit: 2-flop synchroniser, mismatch counter and stable level,
// with single-cycle rise/fall pulses on the edge where the stable level flips.
module pio_debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_bit,
  output logic raw,
  output logic stable,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_reg;
  logic          sync2_reg;
  logic          stable_reg;
  logic [CW-1:0] cnt_reg;
  logic          mismatch;
  logic          accept;

  assign mismatch = sync2_reg ^ stable_reg;
  // The counter would reach DEBOUNCE_CYCLES on this edge: take the new level instead.
  assign accept   = mismatch && (cnt_reg == CNT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_reg  <= 1'b0;
      sync2_reg  <= 1'b0;
      stable_reg <= 1'b0;
      cnt_reg    <= '0;
    end else begin
      sync1_reg <= in_bit;
      sync2_reg <= sync1_reg;
      if (!mismatch || accept) begin
        cnt_reg <= '0;
      end else begin
        cnt_reg <= cnt_reg + CW'(1);
      end
      if (accept) begin
        stable_reg <= sync2_reg;
      end
    end
  end

  assign raw    = sync2_reg;
  assign stable = stable_reg;
  assign rise   = accept & sync2_reg;
  assign fall   = accept & ~sync2_reg;

endmodule

// File: rtl/debounced_input_pio.sv
// Avalon-MM input PIO with per-bit debouncing, edge capture (W1C, set wins),
// per-bit rise/fall enables, interrupt mask and a registered read mux.
module debounced_input_pio
  import debounced_input_pio_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  input  logic [WIDTH-1:0]  in_port,
  output logic [31:0]       readdata,
  output logic              irq
);

  logic [WIDTH-1:0] raw_bits;
  logic [WIDTH-1:0] stable_bits;
  logic [WIDTH-1:0] rise_bits;
  logic [WIDTH-1:0] fall_bits;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      pio_debounce_bit #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_bit (
        .clk    (clk),
        .reset_n(reset_n),
        .in_bit (in_port[gi]),
        .raw    (raw_bits[gi]),
        .stable (stable_bits[gi]),
        .rise   (rise_bits[gi]),
        .fall   (fall_bits[gi])
      );
    end
  endgenerate

  logic [WIDTH-1:0] irq_mask_reg;
  logic [WIDTH-1:0] edge_cap_reg;
  logic [WIDTH-1:0] rise_en_reg;
  logic [WIDTH-1:0] fall_en_reg;
  logic [31:0]      readdata_reg;
  logic [31:0]      readdata_next;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] edge_set;
  logic [WIDTH-1:0] edge_clr;
  logic             wr_en;
  logic             unused_wdata;

  assign wr_en        = chipselect & ~write_n;
  assign wdata        = writedata[WIDTH-1:0];
  assign unused_wdata = ^writedata;
  assign edge_set     = (rise_bits & rise_en_reg) | (fall_bits & fall_en_reg);
  assign edge_clr     = (wr_en && address == ADDR_EDGE_CAPTURE) ? wdata : '0;

  always_comb begin
    readdata_next = '0;
    case (address)
      ADDR_DATA:         readdata_next[WIDTH-1:0] = stable_bits;
      ADDR_RAW:          readdata_next[WIDTH-1:0] = raw_bits;
      ADDR_IRQ_MASK:     readdata_next[WIDTH-1:0] = irq_mask_reg;
      ADDR_EDGE_CAPTURE: readdata_next[WIDTH-1:0] = edge_cap_reg;
      ADDR_RISE_EN:      readdata_next[WIDTH-1:0] = rise_en_reg;
      ADDR_FALL_EN:      readdata_next[WIDTH-1:0] = fall_en_reg;
      default:           readdata_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask_reg <= '0;
      edge_cap_reg <= '0;
      rise_en_reg  <= '0;
      fall_en_reg  <= '0;
      readdata_reg <= '0;
    end else begin
      readdata_reg <= readdata_next;
      // Set after clear so an edge arriving with a W1C on the same bit survives.
      edge_cap_reg <= (edge_cap_reg & ~edge_clr) | edge_set;
      if (wr_en && address == ADDR_IRQ_MASK) irq_mask_reg <= wdata;
      if (wr_en && address == ADDR_RISE_EN)  rise_en_reg  <= wdata;
      if (wr_en && address == ADDR_FALL_EN)  fall_en_reg  <= wdata;
    end
  end

  assign readdata = readdata_reg;
  assign irq      = |(edge_cap_reg & irq_mask_reg);

endmodule

// File: tb/tb_debounced_input_pio.sv
// Bench for debounced_input_pio (WIDTH=4, DEBOUNCE_CYCLES=8): CSR vector table,
// hand-written debounce corner sequences, then random traffic against a window-based model.
module tb_debounced_input_pio;
  import debounced_input_pio_pkg::*;

  localparam int W = 4;
  localparam int N = 8;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write_n;
  logic [31:0]       writedata;
  logic [W-1:0]      in_port;
  logic [31:0]       readdata;
  logic              irq;

  always #5 clk = ~clk;

  debounced_input_pio #(
    .WIDTH(W),
    .DEBOUNCE_CYCLES(N)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .in_port   (in_port),
    .readdata  (readdata),
    .irq       (irq)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: a level is accepted once the last N synchronised samples all differ from it.
  logic [W-1:0] m_s1, m_s2, m_stable, m_cap, m_mask, m_ren, m_fen;
  logic [31:0]  m_rd;
  logic [W-1:0] m_win[$];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_s1 = '0; m_s2 = '0; m_stable = '0; m_cap = '0;
    m_mask = '0; m_ren = '0; m_fen = '0; m_rd = '0;
    m_win.delete();
    for (int i = 0; i < N; i++) m_win.push_back('0);
  endfunction

  function automatic logic m_irq();
    return |(m_cap & m_mask);
  endfunction

  function automatic void model_edge();
    logic [W-1:0] acc, nstab, rise, fall, clr;
    logic         wr;
    if (!reset_n) begin
      model_reset();
      return;
    end
    acc = '0;
    for (int b = 0; b < W; b++) begin
      bit all_diff = 1'b1;
      foreach (m_win[i]) if (m_win[i][b] == m_stable[b]) all_diff = 1'b0;
      acc[b] = all_diff;
    end
    case (address)
      3'd0:    m_rd = {28'b0, m_stable};
      3'd1:    m_rd = {28'b0, m_s2};
      3'd2:    m_rd = {28'b0, m_mask};
      3'd3:    m_rd = {28'b0, m_cap};
      3'd4:    m_rd = {28'b0, m_ren};
      3'd5:    m_rd = {28'b0, m_fen};
      default: m_rd = 32'h0;
    endcase
    nstab = m_stable ^ acc;
    rise  = acc & nstab;
    fall  = acc & ~nstab;
    wr    = chipselect && !write_n;
    clr   = (wr && address == 3'd3) ? writedata[W-1:0] : '0;
    m_cap = (m_cap & ~clr) | (rise & m_ren) | (fall & m_fen);
    if (wr && address == 3'd2) m_mask = writedata[W-1:0];
    if (wr && address == 3'd4) m_ren  = writedata[W-1:0];
    if (wr && address == 3'd5) m_fen  = writedata[W-1:0];
    m_stable = nstab;
    m_s2 = m_s1;
    m_s1 = in_port;
    void'(m_win.pop_front());
    m_win.push_back(m_s2);
  endfunction

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check("model_readdata", readdata, m_rd);
    check("model_irq", {31'b0, irq}, {31'b0, m_irq()});
  endtask

  task automatic idle(int n);
    repeat (n) tick();
  endtask

  task automatic csr_write(logic [ADDR_W-1:0] a, logic [31:0] d);
    address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
    $display("write addr=%0d data=0x%08h", a, d);
  endtask

  task automatic csr_read(logic [ADDR_W-1:0] a, output logic [31:0] v);
    address = a;
    tick();
    v = readdata;
    $display("read  addr=%0d data=0x%08h", a, v);
  endtask

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [31:0]       wdata;
    logic [31:0]       exp_rd;
  } vec_t;

  vec_t vecs[18];

  initial begin
    logic [31:0] v;
    int hold;

    vecs[0]  = '{3'd2, 1'b1, 32'hFFFF_FFFF, 32'h0};
    vecs[1]  = '{3'd2, 1'b0, 32'h0,         32'hF};
    vecs[2]  = '{3'd4, 1'b1, 32'hFFFF_FFFF, 32'h0};
    vecs[3]  = '{3'd4, 1'b0, 32'h0,         32'hF};
    vecs[4]  = '{3'd5, 1'b1, 32'h0000_000A, 32'h0};
    vecs[5]  = '{3'd5, 1'b0, 32'h0,         32'hA};
    vecs[6]  = '{3'd6, 1'b1, 32'hFFFF_FFFF, 32'h0};
    vecs[7]  = '{3'd6, 1'b0, 32'h0,         32'h0};
    vecs[8]  = '{3'd0, 1'b1, 32'h0000_000F, 32'h0};
    vecs[9]  = '{3'd0, 1'b0, 32'h0,         32'h0};
    vecs[10] = '{3'd1, 1'b1, 32'h0000_000F, 32'h0};
    vecs[11] = '{3'd1, 1'b0, 32'h0,         32'h0};
    vecs[12] = '{3'd7, 1'b1, 32'h0000_000F, 32'h0};
    vecs[13] = '{3'd7, 1'b0, 32'h0,         32'h0};
    vecs[14] = '{3'd2, 1'b1, 32'h0,         32'hF};
    vecs[15] = '{3'd2, 1'b0, 32'h0,         32'h0};
    vecs[16] = '{3'd5, 1'b1, 32'h0,         32'hA};
    vecs[17] = '{3'd5, 1'b0, 32'h0,         32'h0};

    reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; in_port = '0;
    model_reset();
    idle(2);
    check("reset_readdata", readdata, 32'h0);
    check("reset_irq", {31'b0, irq}, 32'h0);
    reset_n = 1'b1;
    idle(2);

    // CSR access table: exp_rd is readdata after the vector's own clock edge.
    foreach (vecs[i]) begin
      address = vecs[i].addr; writedata = vecs[i].wdata;
      chipselect = vecs[i].we; write_n = !vecs[i].we;
      tick();
      check($sformatf("vec%0d_readdata", i), readdata, vecs[i].exp_rd);
      $display("vec %0d addr=%0d we=%0d wdata=0x%08h readdata=0x%08h", i,
               vecs[i].addr, vecs[i].we, vecs[i].wdata, readdata);
    end
    chipselect = 1'b0; write_n = 1'b1;

    // Clean rise on bit0: DATA register flips on edge 10, visible on readdata at edge 11.
    csr_write(ADDR_RISE_EN, 32'h1);
    csr_write(ADDR_IRQ_MASK, 32'h1);
    address = ADDR_DATA;
    in_port[0] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 9)  check("rise_irq_k9", {31'b0, irq}, 32'h0);
      if (k == 10) check("rise_irq_k10", {31'b0, irq}, 32'h1);
      if (k == 10) check("rise_data_k10", readdata, 32'h0);
      if (k == 11) check("rise_data_k11", readdata, 32'h1);
    end
    csr_read(ADDR_EDGE_CAPTURE, v);
    check("rise_capture", v, 32'h1);

    // Glitch shorter than the debounce window is ignored.
    address = ADDR_DATA;
    in_port[1] = 1'b1;
    idle(5);
    in_port[1] = 1'b0;
    idle(15);
    check("glitch_data", readdata, 32'h1);
    check("glitch_irq", {31'b0, irq}, 32'h1);
    csr_read(ADDR_EDGE_CAPTURE, v);
    check("glitch_capture", v, 32'h1);

    // Fall with FALL_EN=0 is not captured.
    csr_write(ADDR_RISE_EN, 32'hF);
    csr_write(ADDR_FALL_EN, 32'h0);
    in_port[2] = 1'b1;
    idle(12);
    csr_write(ADDR_EDGE_CAPTURE, 32'h4);
    in_port[2] = 1'b0;
    idle(12);
    csr_read(ADDR_DATA, v);
    check("fall_data", v, 32'h1);
    csr_read(ADDR_EDGE_CAPTURE, v);
    check("fall_capture", v, 32'h1);

    // W1C collides with a new bit0 rise: the set wins.
    in_port[1] = 1'b1;
    idle(12);
    in_port[0] = 1'b0;
    idle(12);
    csr_read(ADDR_EDGE_CAPTURE, v);
    check("collide_pre_capture", v, 32'h3);
    in_port[0] = 1'b1;
    idle(9);
    csr_write(ADDR_EDGE_CAPTURE, 32'h1);
    csr_read(ADDR_EDGE_CAPTURE, v);
    check("collide_capture", v, 32'h3);
    csr_write(ADDR_EDGE_CAPTURE, 32'h2);
    csr_read(ADDR_EDGE_CAPTURE, v);
    check("w1c_capture", v, 32'h1);
    csr_read(ADDR_DATA, v);
    check("collide_data", v, 32'h3);

    // Reset mid-debounce: the partial count is lost and a full window restarts.
    address = ADDR_DATA;
    in_port[3] = 1'b1;
    idle(7);
    reset_n = 1'b0;
    model_reset();
    #1;
    check("midreset_readdata", readdata, 32'h0);
    check("midreset_irq", {31'b0, irq}, 32'h0);
    idle(2);
    reset_n = 1'b1;
    csr_write(ADDR_RISE_EN, 32'h8);
    csr_write(ADDR_IRQ_MASK, 32'h8);
    address = ADDR_DATA;
    for (int k = 3; k <= 12; k++) begin
      tick();
      if (k <= 10) check($sformatf("rerise_data_k%0d", k), readdata, 32'h0);
      if (k == 9)  check("rerise_irq_k9", {31'b0, irq}, 32'h0);
      if (k == 10) check("rerise_irq_k10", {31'b0, irq}, 32'h1);
      if (k == 11) check("rerise_data_k11", readdata, 32'hB);
    end

    // Random traffic against the model.
    hold = 1;
    for (int c = 0; c < 3000; c++) begin
      hold--;
      if (hold == 0) begin
        in_port = W'($urandom);
        hold = $urandom_range(1, 14);
      end
      address    = ADDR_W'($urandom_range(0, 7));
      chipselect = ($urandom_range(0, 3) == 0);
      write_n    = $urandom_range(0, 1);
      writedata  = $urandom;
      tick();
    end
    chipselect = 1'b0; write_n = 1'b1;
    $display("random phase done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/debounced_input_pio.md
DEBOUNCED_INPUT_PIO -- requirements
Module: debounced_input_pio

Interface
REQ-001 Parameter WIDTH, default 4: number of input bits; legal range 1..32.
REQ-002 Parameter DEBOUNCE_CYCLES, default 50000: consecutive stable cycles required to accept a new input level; legal range >= 1.
REQ-003 clk  input  1  Clock; all logic is rising-edge.
REQ-004 reset_n  input  1  Reset, asynchronous, active-low; clock clk.
REQ-005 address  input  3  Avalon-MM word address.
REQ-006 chipselect  input  1  Slave select.
REQ-007 write_n  input  1  Active-low write strobe, qualified by chipselect.
REQ-008 writedata  input  32  Write data; bits above WIDTH-1 are ignored.
REQ-009 in_port  input  WIDTH  Asynchronous raw inputs (buttons or switches).
REQ-010 readdata  output  32  Registered read data; bits above WIDTH-1 are always 0.
REQ-011 irq  output  1  Level interrupt request.

Function
REQ-012 Register map: 0 DATA (debounced, RO); 1 RAW (synchronised, RO); 2 IRQ_MASK (RW); 3 EDGE_CAPTURE (write-1-to-clear); 4 RISE_EN (RW); 5 FALL_EN (RW); addresses 6 and 7 read 0 and ignore writes.
REQ-013 readdata updates every clock to the mux value selected by the current address, so read latency is 1 cycle; chipselect does not gate the read mux.
REQ-014 A write takes effect on the clock edge where chipselect=1 and write_n=0; writes to RO addresses have no effect.
REQ-015 Each in_port bit passes through a 2-flop synchroniser; RAW returns the second flop.
REQ-016 Per bit, a counter of width $clog2(DEBOUNCE_CYCLES+1) resets to 0 whenever RAW equals the stable bit and increments otherwise.
REQ-017 When the counter reaches DEBOUNCE_CYCLES, the stable bit takes the RAW value and the counter clears on that same edge.
REQ-018 Total delay from an in_port change to DATA = 2 + DEBOUNCE_CYCLES cycles; any mismatch run shorter than DEBOUNCE_CYCLES produces no DATA change.
REQ-019 A stable 0->1 change sets the EDGE_CAPTURE bit if its RISE_EN bit = 1; a 1->0 change sets it if its FALL_EN bit = 1.
REQ-020 EDGE_CAPTURE bits are sticky; writing 1 to a bit clears it, and writing 0 leaves it unchanged.
REQ-021 If a clear and a new edge hit the same bit in the same cycle, the set wins, so no edge is lost.
REQ-022 irq = OR over bits of (EDGE_CAPTURE & IRQ_MASK), combinational from registers with no added latency.
REQ-023 Changing RISE_EN or FALL_EN does not alter existing capture bits.

Reset
REQ-024 While reset_n=0, the following are held at 0: synchroniser flops, counters, stable bits, IRQ_MASK, EDGE_CAPTURE, RISE_EN, FALL_EN and readdata; irq is therefore 0.
REQ-025 Reset mid-debounce discards the partial count; after release, an input held at 1 needs a full 2 + DEBOUNCE_CYCLES cycles to reach DATA and then produces a rising edge.

Structure
REQ-026 A shared package debounced_input_pio_pkg holds the register offset constants (DATA, RAW, IRQ_MASK, EDGE_CAPTURE, RISE_EN, FALL_EN) and the address width.
REQ-027 A sub-module pio_debounce_bit (synchroniser, counter, stable bit, rise/fall pulses) is instantiated WIDTH times by a generate loop.
REQ-028 The top level holds the CSRs, capture logic, irq and read mux.

Verification (WIDTH=4, DEBOUNCE_CYCLES=8)
REQ-029 RISE_EN=0x1, IRQ_MASK=0x1, in_port[0] 0->1 held 12 cycles -> DATA[0]=1 exactly 10 cycles after the change, EDGE_CAPTURE=0x1, irq=1.
REQ-030 in_port[1] pulsed high for 5 cycles -> DATA, EDGE_CAPTURE and irq unchanged.
REQ-031 FALL_EN=0x0, RISE_EN=0xF, bit2 1->0 held 12 cycles -> DATA[2]=0 and EDGE_CAPTURE[2]=0.
REQ-032 EDGE_CAPTURE=0x3; write 0x1 to address 3 in the same cycle as a new bit0 rise -> EDGE_CAPTURE=0x3; then write 0x2 -> EDGE_CAPTURE=0x1.
REQ-033 Read address 4 after writing 0xFFFFFFFF -> readdata=0x0000000F one cycle later; read address 6 -> 0x00000000.
REQ-034 Assert reset_n low at count 5 of a bit3 rise, release, hold the input high -> DATA[3]=1 10 cycles after release with no earlier change.
